// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controllers: state encoding and ALU opcodes.
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_SUB   = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5,
      ST_DZ    = 3'd6
   } ctrl_state_e;

   localparam logic [5:0] ALU_NOP = 6'd0;
   localparam logic [5:0] ALU_ADD = 6'd27;
   localparam logic [5:0] ALU_SUB = 6'd28;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider: clear, increment, terminal flag at WIDTH-1.
module div_iter_counter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign last  = (count_q == CNT_W'(WIDTH - 1));
   assign count = count_q;

   // Stepping past the terminal value returns to zero so the count can never
   // run beyond WIDTH-1 into a phantom extra iteration.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = last ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/div_control.sv
// Restoring-division sequencer driving the shared ALU and remainder/quotient registers.
//
// state | meaning
// IDLE  | waiting for run
// LOAD  | load dividend/divisor, clear iteration count
// SHIFT | shift {remainder, quotient} left by one
// SUB   | ALU computes remainder - divisor
// CHECK | write quotient bit, store difference if non-negative
// DONE  | result valid, waiting for run
// DZ    | divisor was zero, waiting for run
module div_control #(
   parameter int         WIDTH   = 32,
   parameter logic [5:0] ALU_SUB = 6'd28,
   parameter int         CNT_W   = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       div_zero,
   input  logic       rem_msb,
   output logic       wrctrl,
   output logic       shlctrl,
   output logic [5:0] addctrl,
   output logic       strctrl,
   output logic       qwr,
   output logic       qbit,
   output logic       busy,
   output logic       ready,
   output logic       dz
);

   import alu_ctrl_pkg::*;

   ctrl_state_e      state_q;
   ctrl_state_e      state_d;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_last;
   logic [CNT_W-1:0] cnt_val;

   div_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (cnt_val),
      .last  (cnt_last)
   );

   always_comb begin
      state_d = state_q;
      wrctrl  = 1'b0;
      shlctrl = 1'b0;
      addctrl = ALU_NOP;
      strctrl = 1'b0;
      qwr     = 1'b0;
      qbit    = 1'b0;
      busy    = 1'b0;
      ready   = 1'b0;
      dz      = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            wrctrl  = 1'b1;
            busy    = 1'b1;
            cnt_clr = 1'b1;
            state_d = div_zero ? ST_DZ : ST_SHIFT;
         end
         ST_SHIFT: begin
            shlctrl = 1'b1;
            busy    = 1'b1;
            state_d = ST_SUB;
         end
         ST_SUB: begin
            addctrl = ALU_SUB;
            busy    = 1'b1;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            // A negative difference means restore: simply skip the store.
            addctrl = ALU_SUB;
            qwr     = 1'b1;
            busy    = 1'b1;
            strctrl = ~rem_msb;
            qbit    = ~rem_msb;
            cnt_inc = 1'b1;
            state_d = cnt_last ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: begin
            ready = 1'b1;
            if (run) state_d = ST_LOAD;
         end
         ST_DZ: begin
            ready = 1'b1;
            dz    = 1'b1;
            if (run) state_d = ST_LOAD;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_div_control.sv
// Bench for div_control: behavioural datapath plus arithmetic reference for quotient, remainder and timing.
module tb_div_control;
   import alu_ctrl_pkg::*;

   localparam int WIDTH = 32;
   localparam int READY_CYC = 3 * WIDTH + 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       div_zero;
   logic       rem_msb;
   logic       wrctrl, shlctrl, strctrl, qwr, qbit, busy, ready, dz;
   logic [5:0] addctrl;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0] dvd = '0, dvs = 32'd1;
   logic [32:0] rem_m = '0;
   logic [31:0] quo_m = '0, dvs_m = 32'd1;
   logic s_wr = 0, s_shl = 0, s_str = 0, s_qwr = 0, s_qb = 0;
   int n_wr, n_shl, n_str, n_qwr, n_q1, n_add, n_both;

   div_control #(.WIDTH(WIDTH), .ALU_SUB(6'd28)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .div_zero(div_zero), .rem_msb(rem_msb),
      .wrctrl(wrctrl), .shlctrl(shlctrl), .addctrl(addctrl), .strctrl(strctrl),
      .qwr(qwr), .qbit(qbit), .busy(busy), .ready(ready), .dz(dz)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Behavioural datapath: divisor-zero flag from the input bus, sign of remainder - divisor.
   assign div_zero = (dvs == 32'd0);
   assign rem_msb  = (rem_m < {1'b0, dvs_m});

   always @(negedge clk) begin
      s_wr  <= wrctrl;
      s_shl <= shlctrl;
      s_str <= strctrl;
      s_qwr <= qwr;
      s_qb  <= qbit;
      if (wrctrl) n_wr++;
      if (shlctrl) n_shl++;
      if (strctrl) n_str++;
      if (qwr) n_qwr++;
      if (qwr && qbit) n_q1++;
      if (addctrl != 6'd0) n_add++;
      if (busy && ready) n_both++;
   end

   always @(posedge clk) begin
      if (s_wr) begin
         rem_m <= '0;
         quo_m <= dvd;
         dvs_m <= dvs;
      end else begin
         if (s_shl) begin
            rem_m <= {rem_m[31:0], quo_m[31]};
            quo_m <= {quo_m[30:0], 1'b0};
         end
         if (s_str) rem_m <= rem_m - {1'b0, dvs_m};
         if (s_qwr) quo_m[0] <= s_qb;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] all_outs();
      return {wrctrl, shlctrl, addctrl, strctrl, qwr, qbit, busy, ready, dz};
   endfunction

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      dvd = a; dvs = b; run = 1'b1;
      n_wr = 0; n_shl = 0; n_str = 0; n_qwr = 0; n_q1 = 0; n_add = 0; n_both = 0;
      @(posedge clk); #1;
      run = 1'b0;
      cyc = 1;
      chk("load_wrctrl", wrctrl, 1);
      chk("load_busy_ready", {busy, ready}, 2'b10);
   endtask

   task automatic wait_ready(input bit toggle, output int rc);
      while (!ready && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         run = toggle && (cyc == 10 || cyc == 50);
      end
      run = 1'b0;
      rc = ready ? cyc : -1;
   endtask

   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input bit toggle);
      int rc;
      logic [31:0] q, r;
      q = a / b;
      r = a % b;
      start_op(a, b);
      wait_ready(toggle, rc);
      chk({tag, "_ready_cycle"}, rc, READY_CYC);
      chk({tag, "_quotient"}, quo_m, q);
      chk({tag, "_remainder"}, rem_m, {1'b0, r});
      chk({tag, "_dz"}, dz, 0);
      chk({tag, "_wr_pulses"}, n_wr, 1);
      chk({tag, "_shl_pulses"}, n_shl, WIDTH);
      chk({tag, "_qwr_pulses"}, n_qwr, WIDTH);
      chk({tag, "_str_pulses"}, n_str, $countones(q));
      chk({tag, "_qbit_ones"}, n_q1, $countones(q));
      chk({tag, "_sub_cycles"}, n_add, 2 * WIDTH);
      chk({tag, "_busy_and_ready"}, n_both, 0);
   endtask

   initial begin
      int rc;
      logic [31:0] ra, rb;
      #1;
      chk("reset_outputs", all_outs(), 14'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_outputs", all_outs(), 14'd0);

      do_op("div_100_7", 32'd100, 32'd7, 1'b0);

      // Restart straight out of DONE with operands 7/100.
      do_op("div_7_100", 32'd7, 32'd100, 1'b0);

      start_op(32'd55, 32'd0);
      wait_ready(1'b0, rc);
      chk("dz_ready_cycle", rc, 2);
      chk("dz_flag", dz, 1);
      chk("dz_no_shift", n_shl, 0);
      chk("dz_no_store", n_str, 0);
      chk("dz_no_alu", n_add, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("dz_held", {busy, ready, dz}, 3'b011);

      do_op("div_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
      do_op("div_100_7_runtoggle", 32'd100, 32'd7, 1'b1);

      start_op(32'd1000, 32'd3);
      while (cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      rst_n = 1'b0;
      #1;
      chk("midop_reset_outputs", all_outs(), 14'd0);
      chk("midop_reset_state", dut.state_q, ST_IDLE);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_idle", all_outs(), 14'd0);
      do_op("div_9_4", 32'd9, 32'd4, 1'b0);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (rb == 32'd0) rb = 32'd1;
         do_op("random", ra, rb, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
